// File: rtl/rx_control_module.sv
// rtl/rx_control_module.sv - UART 8N1 receive controller; define RX_PARITY_EN for an even-parity bit before the stop bit
module rx_control_module #(
  parameter int BPS_DIV  = 5208,
  parameter int HALF_DIV = BPS_DIV / 2
) (
  input  logic       CLOCK,
  input  logic       RST_n,
  input  logic       RX_Pin_In,
  input  logic       RX_En_Sig,
  output logic [7:0] RX_Data,
  output logic       RX_Done_Sig,
`ifdef RX_PARITY_EN
  output logic       RX_Frame_Err,
  output logic       RX_Parity_Err
`else
  output logic       RX_Frame_Err
`endif
);

  localparam int CW = $clog2(BPS_DIV);
  localparam logic [CW-1:0] FULL_TGT = CW'(BPS_DIV - 1);
  localparam logic [CW-1:0] HALF_TGT = CW'(HALF_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            prev_q, prev_d;
`ifdef RX_PARITY_EN
  logic            par_q, par_d;
  logic            perr_q, perr_d;
`endif

  logic            rx_bit;
  logic            fall;
  logic            strobe;

  // Synchronised line, its falling edge, and the per-state sample strobe.
  assign rx_bit = sync2_q;
  assign fall   = prev_q & ~sync2_q;
  assign strobe = (state_q == S_START) ? (cnt_q == HALF_TGT) : (cnt_q == FULL_TGT);

  // Next-state, datapath and output-pulse logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    sync1_d = RX_Pin_In;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
`ifdef RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (fall && RX_En_Sig) state_d = S_START;
      end
      S_START: begin
        if (strobe) begin
          idx_d   = 3'd0;
          state_d = rx_bit ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (strobe) begin
          shift_d[idx_q] = rx_bit;
          if (idx_q == 3'd7) begin
`ifdef RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef RX_PARITY_EN
      S_PARITY: begin
        if (strobe) begin
          par_d   = rx_bit;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (strobe) begin
          if (rx_bit) begin
            state_d = S_IDLE;
`ifdef RX_PARITY_EN
            if (^{shift_q, par_q}) begin
              perr_d = 1'b1;
            end else begin
              data_d = shift_q;
              done_d = 1'b1;
            end
`else
            data_d = shift_q;
            done_d = 1'b1;
`endif
          end else begin
            // Stop bit low: flag it and wait out the held-low line.
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_bit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Disable aborts any frame in progress without reporting anything.
    if (!RX_En_Sig) begin
      state_d = S_IDLE;
      idx_d   = 3'd0;
      data_d  = data_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
`ifdef RX_PARITY_EN
      perr_d  = 1'b0;
`endif
    end

    // Baud counter restarts on every state entry and is parked while waiting.
    if ((state_d != state_q) || (state_q == S_IDLE) || (state_q == S_BREAK)) begin
      cnt_d = '0;
    end else if (cnt_q == FULL_TGT) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State and datapath registers; the line synchroniser resets to idle-high.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
`ifdef RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
`ifdef RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign RX_Data      = data_q;
  assign RX_Done_Sig  = done_q;
  assign RX_Frame_Err = ferr_q;
`ifdef RX_PARITY_EN
  assign RX_Parity_Err = perr_q;
`endif

endmodule
